// File: rtl/sys_mem_ctrl_pkg.sv
// Shared system-bus constants and types for the cache/memory-controller pair.
package sys_mem_ctrl_pkg;

    // Request direction encodings on SysRW
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Default geometry and timing
    localparam int unsigned WAITSTATE_DEF = 2;
    localparam int unsigned OFS_DEF       = 4;
    localparam int unsigned MEM_AW_DEF    = 30;

    // Bus and counter widths
    localparam int unsigned SYS_AW  = 32;
    localparam int unsigned SYS_DW  = 32;
    localparam int unsigned WADDR_W = SYS_AW - 2;
    localparam int unsigned WCNT_W  = 2;

    // Controller state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Request captured in IDLE and held for the whole transaction
    typedef struct packed {
        logic               rw;
        logic [WADDR_W-1:0] waddr;
        logic [SYS_DW-1:0]  wdata;
    } sys_req_t;

    // Words per cache line for a given offset width
    function automatic int unsigned line_words(input int unsigned ofs);
        return 32'd1 << ofs;
    endfunction

endpackage

// File: rtl/sys_mem_ctrl_wait_timer.sv
// Loadable wait-state down-counter; flags the last wait cycle when it reaches zero.
module sys_mem_ctrl_wait_timer
    import sys_mem_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [WCNT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              last_c_o
);

    logic [WCNT_W-1:0] cnt_q;
    logic [WCNT_W-1:0] cnt_d;

    // Reload per beat, count down while waiting, saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WCNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c_o = (cnt_q == '0);

endmodule

// File: rtl/sys_mem_ctrl.sv
// System-bus responder: 16-beat line fills and single-word write-through stores
// against a synchronous single-port SRAM, with programmable wait states.
module sys_mem_ctrl
    import sys_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAITSTATE = WAITSTATE_DEF,
    parameter int unsigned OFS       = OFS_DEF,
    parameter int unsigned MEM_AW    = MEM_AW_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              SysStrobe,
    input  logic              SysRW,
    input  logic [SYS_AW-1:0] SysAddress,
    input  logic [SYS_DW-1:0] SysData_in,
    output logic [SYS_DW-1:0] SysData_out,
    output logic              SysAck,
    output logic              SysReady,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [SYS_DW-1:0] mem_wdata,
    input  logic [SYS_DW-1:0] mem_rdata
);

    localparam logic [OFS-1:0]     BEAT_LAST = OFS'(line_words(OFS) - 1);
    localparam logic [WADDR_W-1:0] LINE_MASK = WADDR_W'(line_words(OFS) - 1);
    localparam logic [WCNT_W-1:0]  WAIT_LOAD = WCNT_W'(WAITSTATE - 1);

    logic [1:0]        state_q,     state_d;
    sys_req_t          req_q,       req_d;
    logic [OFS-1:0]    beat_q,      beat_d;
    logic              ack_q,       ack_d;
    logic              ready_q,     ready_d;
    logic              mem_rd_q,    mem_rd_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
    logic [SYS_DW-1:0] mem_wdata_q, mem_wdata_d;

    logic tmr_load_c;
    logic tmr_dec_c;
    logic tmr_last_c;

    // Byte-lane bits of the address carry no meaning on a word bus
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^SysAddress[1:0];

    sys_mem_ctrl_wait_timer u_wait_timer (
        .clk_i      (clock),
        .rst_n_i    (reset),
        .load_i     (tmr_load_c),
        .load_val_i (WAIT_LOAD),
        .dec_i      (tmr_dec_c),
        .last_c_o   (tmr_last_c)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        beat_d      = beat_q;
        ack_d       = 1'b0;
        ready_d     = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tmr_load_c  = 1'b0;
        tmr_dec_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (SysStrobe) begin
                    req_d.rw    = SysRW;
                    req_d.waddr = (SysRW == RW_WRITE) ? SysAddress[SYS_AW-1:2]
                                                      : (SysAddress[SYS_AW-1:2] & ~LINE_MASK);
                    req_d.wdata = SysData_in;
                    beat_d      = '0;
                    tmr_load_c  = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmr_last_c) begin
                    if (req_q.rw == RW_READ) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = MEM_AW'(req_q.waddr + WADDR_W'(beat_q));
                        state_d    = ST_ACK;
                    end else begin
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = MEM_AW'(req_q.waddr);
                        mem_wdata_d = req_q.wdata;
                        state_d     = ST_DONE;
                    end
                end else begin
                    tmr_dec_c = 1'b1;
                end
            end
            ST_ACK: begin
                ack_d = 1'b1;
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d     = beat_q + OFS'(1);
                    tmr_load_c = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            beat_q      <= '0;
            ack_q       <= 1'b0;
            ready_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            beat_q      <= beat_d;
            ack_q       <= ack_d;
            ready_q     <= ready_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read data is the SRAM output register itself, gated to the ack cycle
    assign SysData_out = ack_q ? mem_rdata : '0;
    assign SysAck      = ack_q;
    assign SysReady    = ready_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Bench for sys_mem_ctrl: three instances (W = 1, 2, 3) sharing clock and reset,
// each with a read-only SRAM model holding 0xA000_0000 + word address.
module tb_sys_mem_ctrl;
    import sys_mem_ctrl_pkg::*;

    localparam int N  = 3;
    localparam int AW = 30;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ACK = 2;
    localparam int K_RDY = 3;

    typedef struct {
        int            cyc;
        int            kind;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } ev_t;

    typedef struct {
        logic          rw;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [AW-1:0] exp_waddr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    logic          strobe [N];
    logic          rw     [N];
    logic [31:0]   addr   [N];
    logic [31:0]   din    [N];
    logic [31:0]   dout   [N];
    logic          ack    [N];
    logic          rdy    [N];
    logic [AW-1:0] maddr  [N];
    logic          mrd    [N];
    logic          mwr    [N];
    logic [31:0]   mwdata [N];

    ev_t exp_q [N][$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [31:0] sram_q;

        always @(posedge clk) begin
            if (mrd[g]) sram_q <= 32'hA000_0000 + 32'(maddr[g]);
        end

        sys_mem_ctrl #(.WAITSTATE(g + 1), .OFS(4), .MEM_AW(AW)) u_dut (
            .clock       (clk),
            .reset       (reset),
            .SysStrobe   (strobe[g]),
            .SysRW       (rw[g]),
            .SysAddress  (addr[g]),
            .SysData_in  (din[g]),
            .SysData_out (dout[g]),
            .SysAck      (ack[g]),
            .SysReady    (rdy[g]),
            .mem_addr    (maddr[g]),
            .mem_rd      (mrd[g]),
            .mem_wr      (mwr[g]),
            .mem_wdata   (mwdata[g]),
            .mem_rdata   (sram_q)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int g);
        chk($sformatf("rst_dout%0d", g),   64'(dout[g]),   64'h0);
        chk($sformatf("rst_ack%0d", g),    64'(ack[g]),    64'h0);
        chk($sformatf("rst_ready%0d", g),  64'(rdy[g]),    64'h0);
        chk($sformatf("rst_maddr%0d", g),  64'(maddr[g]),  64'h0);
        chk($sformatf("rst_mrd%0d", g),    64'(mrd[g]),    64'h0);
        chk($sformatf("rst_mwr%0d", g),    64'(mwr[g]),    64'h0);
        chk($sformatf("rst_mwdata%0d", g), 64'(mwdata[g]), 64'h0);
    endtask

    task automatic push_ev(input int g, input int c, input int k,
                           input logic [AW-1:0] a, input logic [31:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q[g].push_back(e);
    endtask

    // Fill: beat k read issued in cycle k(W+1)+W, acked in (k+1)(W+1); ready at 16(W+1)+1
    task automatic push_read(input int g, input int a0, input logic [AW-1:0] base);
        int w;
        w = g + 1;
        for (int k = 0; k < 16; k++) begin
            push_ev(g, a0 + k * (w + 1) + w, K_RD, base + AW'(k), 32'h0);
            push_ev(g, a0 + (k + 1) * (w + 1), K_ACK, '0, 32'hA000_0000 + 32'(base) + 32'(k));
        end
        push_ev(g, a0 + 16 * (w + 1) + 1, K_RDY, '0, '0);
    endtask

    task automatic push_write(input int g, input int a0, input logic [AW-1:0] wa,
                              input logic [31:0] d);
        int w;
        w = g + 1;
        push_ev(g, a0 + w, K_WR, wa, d);
        push_ev(g, a0 + w + 1, K_RDY, '0, '0);
    endtask

    task automatic observe(input int g, input int k, input logic [AW-1:0] a, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected inst%0d: got kind=%0d cyc=%0d addr=%0h data=%0h, required no event",
                     g, k, cyc, a, d);
        end else begin
            e = exp_q[g].pop_front();
            if (e.cyc != cyc || e.kind != k || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL event inst%0d: got kind=%0d cyc=%0d addr=%0h data=%0h, required kind=%0d cyc=%0d addr=%0h data=%0h",
                         g, k, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    task automatic mon(input int g);
        ev_t e;
        while (exp_q[g].size() != 0 && exp_q[g][0].cyc < cyc) begin
            e = exp_q[g].pop_front();
            checks++;
            errors++;
            $display("FAIL missing inst%0d: got nothing, required kind=%0d at cyc=%0d (now %0d)",
                     g, e.kind, e.cyc, cyc);
        end
        if (mrd[g]) observe(g, K_RD,  maddr[g], 32'h0);
        if (mwr[g]) observe(g, K_WR,  maddr[g], mwdata[g]);
        if (ack[g]) observe(g, K_ACK, '0,       dout[g]);
        if (rdy[g]) observe(g, K_RDY, '0,       32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset) begin
            for (int g = 0; g < N; g++) mon(g);
        end
    endtask

    task automatic issue(input int g, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [AW-1:0] exp_w, input bit hold, output int a0);
        strobe[g] = 1'b1;
        rw[g]     = r;
        addr[g]   = a;
        din[g]    = d;
        if ($isunknown(r)) begin
            errors++;
            $display("FAIL protocol inst%0d: SysRW=%b with SysStrobe high, required 0 or 1", g, r);
        end
        a0 = cyc + 1;
        if (r == RW_READ) push_read(g, a0, exp_w);
        else              push_write(g, a0, exp_w, d);
        if (!hold) begin
            tick();
            strobe[g] = 1'b0;
        end
    endtask

    task automatic wait_done(input int g, input bit scr);
        int n;
        n = 0;
        while (exp_q[g].size() != 0 && n < 400) begin
            tick();
            n++;
            if (scr) begin
                addr[g] = $urandom;
                din[g]  = $urandom;
                rw[g]   = 1'($urandom);
            end
        end
        checks++;
        if (exp_q[g].size() != 0) begin
            errors++;
            $display("FAIL timeout inst%0d: got %0d events pending, required 0", g, exp_q[g].size());
            exp_q[g].delete();
        end
        tick();
    endtask

    initial begin
        vec_t vecs [7];
        int   a0;
        int   n;

        vecs[0] = '{RW_READ,  32'h0000_1234, 32'h0000_0000, 30'h480};
        vecs[1] = '{RW_WRITE, 32'h0000_2008, 32'hDEAD_BEEF, 30'h802};
        vecs[2] = '{RW_READ,  32'hFFFF_FFFF, 32'h1111_1111, 30'h3FFF_FFF0};
        vecs[3] = '{RW_WRITE, 32'h0000_0003, 32'h5555_AAAA, 30'h0};
        vecs[4] = '{RW_READ,  32'h0000_003C, 32'h0000_0000, 30'h0};
        vecs[5] = '{RW_WRITE, 32'hFFFF_FFFC, 32'h0123_4567, 30'h3FFF_FFFF};
        vecs[6] = '{RW_READ,  32'h8000_0040, 32'h9999_9999, 30'h2000_0010};

        reset = 1'b0;
        for (int g = 0; g < N; g++) begin
            strobe[g] = 1'b0;
            rw[g]     = 1'b0;
            addr[g]   = '0;
            din[g]    = '0;
        end

        // Reset state
        repeat (3) tick();
        for (int g = 0; g < N; g++) chk_zero(g);
        reset = 1'b1;
        tick();

        // Vector table on the W = 2 instance; odd entries scramble inputs mid-transaction
        for (int i = 0; i < 7; i++) begin
            issue(1, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp_waddr, 1'b0, a0);
            wait_done(1, (i % 2) == 1);
        end

        // Back-to-back: write then read strobed one cycle after SysReady
        issue(1, RW_WRITE, 32'h0000_2008, 32'hDEAD_BEEF, 30'h802, 1'b0, a0);
        wait_done(1, 1'b0);
        issue(1, RW_READ, 32'h0000_1234, 32'h0, 30'h480, 1'b0, a0);
        wait_done(1, 1'b0);

        // Strobe held through DONE: exactly one extra write, accepted in the SysReady cycle
        issue(1, RW_WRITE, 32'h0000_3010, 32'hFACE_0001, 30'hC04, 1'b1, a0);
        push_write(1, a0 + 4, 30'hC04, 32'hFACE_0001);
        while (cyc < a0 + 4) tick();
        strobe[1] = 1'b0;
        wait_done(1, 1'b0);

        // Reset after the 5th ack of a fill
        issue(1, RW_READ, 32'h0000_1234, 32'h0, 30'h480, 1'b0, a0);
        n = 0;
        for (int t = 0; t < 200 && n < 5; t++) begin
            tick();
            if (ack[1]) n++;
        end
        chk("midfill_ack_count", 64'(n), 64'd5);
        reset = 1'b0;
        while (exp_q[1].size() != 0 && exp_q[1][exp_q[1].size() - 1].cyc > cyc) begin
            void'(exp_q[1].pop_back());
        end
        tick();
        for (int g = 0; g < N; g++) chk_zero(g);
        reset = 1'b1;
        repeat (4) tick();
        issue(1, RW_WRITE, 32'h0000_2008, 32'hDEAD_BEEF, 30'h802, 1'b0, a0);
        wait_done(1, 1'b0);

        // Wait-state sweep on W = 1 and W = 3 with scrambled inputs
        for (int g = 0; g < N; g += 2) begin
            issue(g, RW_READ, 32'h0000_1234, 32'h0, 30'h480, 1'b0, a0);
            wait_done(g, 1'b1);
            issue(g, RW_WRITE, 32'h0000_2008, 32'hDEAD_BEEF, 30'h802, 1'b0, a0);
            wait_done(g, 1'b1);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
